// File: rtl/cpu_dmem_arb.sv
// Byte-addressable data memory shared by the CPU and the hash accelerator.
// One array access per cycle; accel wide reads are assembled beat by beat.
module cpu_dmem_arb #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned CPU_BYTES    = 4,
  parameter int unsigned ACC_WR_BYTES = 4,
  parameter int unsigned ACC_RD_BYTES = 64,
  parameter int unsigned BEAT_BYTES   = 4,
  parameter int unsigned STARVE_LIM   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_cpu_req,
  input  logic                      i_cpu_we,
  input  logic [ADDR_W-1:0]         i_cpu_addr,
  input  logic [CPU_BYTES-1:0]      i_cpu_be,
  input  logic [8*CPU_BYTES-1:0]    i_cpu_wdata,
  output logic                      o_cpu_ack,
  output logic                      o_cpu_rvalid,
  output logic [8*CPU_BYTES-1:0]    o_cpu_rdata,
  input  logic                      i_acc_req,
  input  logic                      i_acc_we,
  input  logic [ADDR_W-1:0]         i_acc_addr,
  input  logic [8*ACC_WR_BYTES-1:0] i_acc_wdata,
  output logic                      o_acc_ack,
  output logic                      o_acc_rvalid,
  output logic [8*ACC_RD_BYTES-1:0] o_acc_rdata,
  output logic                      o_err
);

  localparam int unsigned NBEATS = ACC_RD_BYTES / BEAT_BYTES;
  localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned WW     = $clog2(STARVE_LIM + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  // Access runs past the top of memory when the last byte address carries out.
  function automatic logic f_oob(input logic [ADDR_W-1:0] addr, input int unsigned nbytes);
    logic [ADDR_W:0] last;
    last = {1'b0, addr} + (ADDR_W+1)'(nbytes - 1);
    return last[ADDR_W];
  endfunction

  logic [7:0]                r_mem [2**ADDR_W];
  state_e                    r_state, w_state_nxt;
  logic [WW-1:0]             r_wait_cnt;
  logic [BW-1:0]             r_beat_cnt;
  logic [ADDR_W-1:0]         r_base;
  logic                      r_rd_oob;
  logic                      r_cpu_rvalid, r_acc_rvalid, r_err;
  logic [8*CPU_BYTES-1:0]    r_cpu_rdata;
  logic [8*ACC_RD_BYTES-1:0] r_acc_rdata;

  logic                      w_in_idle, w_force_acc, w_acc_pend, w_cpu_gnt, w_acc_gnt;
  logic                      w_acc_ack, w_beat_rd, w_last_beat, w_beat_oob;
  logic                      w_cpu_oob, w_accw_oob, w_accr_oob;
  logic [BW-1:0]             w_beat_idx;
  logic [ADDR_W-1:0]         w_beat_addr;
  logic [8*CPU_BYTES-1:0]    w_cpu_rd;
  logic [8*BEAT_BYTES-1:0]   w_beat_data;

  assign w_in_idle   = (r_state == StIdle);
  assign w_force_acc = (r_wait_cnt == WW'(STARVE_LIM));
  assign w_acc_pend  = ~w_in_idle | i_acc_req;
  assign w_cpu_gnt   = i_cpu_req & ~w_force_acc;
  assign w_acc_gnt   = w_acc_pend & ~w_cpu_gnt;
  assign w_acc_ack   = w_acc_gnt & w_in_idle & i_acc_req;
  assign w_beat_rd   = w_acc_gnt & (~w_in_idle | ~i_acc_we);

  assign w_cpu_oob   = f_oob(i_cpu_addr, CPU_BYTES);
  assign w_accw_oob  = f_oob(i_acc_addr, ACC_WR_BYTES);
  assign w_accr_oob  = f_oob(i_acc_addr, ACC_RD_BYTES);

  // The grant cycle in idle fetches beat 0 straight from the request address.
  assign w_beat_idx  = w_in_idle ? '0 : r_beat_cnt;
  assign w_beat_addr = w_in_idle ? i_acc_addr
                                 : r_base + ADDR_W'(r_beat_cnt) * ADDR_W'(BEAT_BYTES);
  assign w_beat_oob  = w_in_idle ? w_accr_oob : r_rd_oob;
  assign w_last_beat = (w_beat_idx == BW'(NBEATS - 1));

  always_comb begin
    w_cpu_rd    = '0;
    w_beat_data = '0;
    for (int unsigned i = 0; i < CPU_BYTES; i++) begin
      w_cpu_rd[8*i +: 8] = r_mem[i_cpu_addr + ADDR_W'(i)];
    end
    for (int unsigned j = 0; j < BEAT_BYTES; j++) begin
      w_beat_data[8*j +: 8] = w_beat_oob ? 8'h00 : r_mem[w_beat_addr + ADDR_W'(j)];
    end
  end

  always_ff @(posedge clk) begin
    if (w_cpu_gnt && i_cpu_we && !w_cpu_oob) begin
      for (int unsigned i = 0; i < CPU_BYTES; i++) begin
        if (i_cpu_be[i]) r_mem[i_cpu_addr + ADDR_W'(i)] <= i_cpu_wdata[8*i +: 8];
      end
    end
    if (w_acc_ack && i_acc_we && !w_accw_oob) begin
      for (int unsigned i = 0; i < ACC_WR_BYTES; i++) begin
        r_mem[i_acc_addr + ADDR_W'(i)] <= i_acc_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_beat_rd && !w_last_beat) w_state_nxt = StBurst;
      StBurst: if (w_acc_gnt && w_last_beat) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_wait_cnt   <= '0;
      r_beat_cnt   <= '0;
      r_base       <= '0;
      r_rd_oob     <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_acc_rvalid <= 1'b0;
      r_acc_rdata  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_acc_pend || w_acc_gnt) r_wait_cnt <= '0;
      else if (!w_force_acc)        r_wait_cnt <= r_wait_cnt + WW'(1);
      if (w_beat_rd) begin
        r_beat_cnt <= w_last_beat ? '0 : w_beat_idx + BW'(1);
        r_acc_rdata[int'(w_beat_idx) * 8 * BEAT_BYTES +: 8 * BEAT_BYTES] <= w_beat_data;
      end
      if (w_acc_ack && !i_acc_we) begin
        r_base   <= i_acc_addr;
        r_rd_oob <= w_accr_oob;
      end
      r_acc_rvalid <= w_beat_rd & w_last_beat;
      r_cpu_rvalid <= w_cpu_gnt & ~i_cpu_we;
      if (w_cpu_gnt && !i_cpu_we) r_cpu_rdata <= w_cpu_oob ? '0 : w_cpu_rd;
      r_err <= (w_cpu_gnt & w_cpu_oob) | (w_acc_ack & (i_acc_we ? w_accw_oob : w_accr_oob));
    end
  end

  assign o_cpu_ack    = w_cpu_gnt;
  assign o_acc_ack    = w_acc_ack;
  assign o_cpu_rvalid = r_cpu_rvalid;
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_acc_rvalid = r_acc_rvalid;
  assign o_acc_rdata  = r_acc_rdata;
  assign o_err        = r_err;

endmodule

// File: tb/tb_cpu_dmem_arb.sv
// Bench for cpu_dmem_arb: byte-level memory/arbitration model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cpu_dmem_arb;
  localparam int LIM = 8;
  localparam int NB  = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_we, cpu_ack, cpu_rvalid;
  logic [15:0]  cpu_addr;
  logic [3:0]   cpu_be;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         acc_req, acc_we, acc_ack, acc_rvalid, err;
  logic [15:0]  acc_addr;
  logic [31:0]  acc_wdata;
  logic [511:0] acc_rdata;

  always #5 clk = ~clk;

  cpu_dmem_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cpu_req    (cpu_req),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_be     (cpu_be),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_ack    (cpu_ack),
    .o_cpu_rvalid (cpu_rvalid),
    .o_cpu_rdata  (cpu_rdata),
    .i_acc_req    (acc_req),
    .i_acc_we     (acc_we),
    .i_acc_addr   (acc_addr),
    .i_acc_wdata  (acc_wdata),
    .o_acc_ack    (acc_ack),
    .o_acc_rvalid (acc_rvalid),
    .o_acc_rdata  (acc_rdata),
    .o_err        (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: memory as a byte array, accel wait age, burst progress.
  bit   [7:0]   mem_m [65536];
  int           m_wait = 0, m_beat = 0, m_base = 0;
  bit           m_active = 1'b0, m_oob = 1'b0;
  logic         e_cpu_rvalid = 1'b0, e_acc_rvalid = 1'b0, e_err = 1'b0;
  logic [31:0]  e_cpu_rdata = '0;
  logic [511:0] e_acc_rdata = '0;

  initial begin : model
    bit gc, ga, pend, oob;
    int idx;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_wait = 0; m_beat = 0; m_active = 1'b0;
        e_cpu_rvalid = 1'b0; e_cpu_rdata = '0;
        e_acc_rvalid = 1'b0; e_acc_rdata = '0; e_err = 1'b0;
      end else begin
        gc   = cpu_req && (m_wait < LIM);
        pend = m_active || acc_req;
        ga   = pend && !gc;
        e_cpu_rvalid = 1'b0; e_acc_rvalid = 1'b0; e_err = 1'b0;
        if (gc) begin
          oob   = (int'(cpu_addr) + 4 > 65536);
          e_err = oob;
          if (cpu_we) begin
            if (!oob) for (int k = 0; k < 4; k++)
              if (cpu_be[k]) mem_m[int'(cpu_addr) + k] = cpu_wdata[8*k +: 8];
          end else begin
            e_cpu_rvalid = 1'b1;
            for (int k = 0; k < 4; k++)
              e_cpu_rdata[8*k +: 8] = oob ? 8'h00 : mem_m[(int'(cpu_addr) + k) % 65536];
          end
        end
        if (ga) begin
          if (!m_active && acc_we) begin
            oob   = (int'(acc_addr) + 4 > 65536);
            e_err = oob;
            if (!oob) for (int k = 0; k < 4; k++) mem_m[int'(acc_addr) + k] = acc_wdata[8*k +: 8];
          end else begin
            if (!m_active) begin
              m_active = 1'b1; m_beat = 0; m_base = int'(acc_addr);
              m_oob = (m_base + 64 > 65536);
              e_err = m_oob;
            end
            for (int k = 0; k < 4; k++) begin
              idx = m_beat * 4 + k;
              e_acc_rdata[8*idx +: 8] = m_oob ? 8'h00 : mem_m[(m_base + idx) % 65536];
            end
            m_beat++;
            if (m_beat == NB) begin
              m_active = 1'b0;
              e_acc_rvalid = 1'b1;
            end
          end
        end
        if (!pend || ga) m_wait = 0;
        else if (m_wait < LIM) m_wait++;
      end
    end
  end

  initial begin : compare
    logic e_cack;
    forever begin
      @(negedge clk);
      e_cack = cpu_req && (m_wait < LIM);
      check("cpu_ack", 512'(cpu_ack), 512'(e_cack));
      check("acc_ack", 512'(acc_ack), 512'(!m_active && acc_req && !e_cack));
      check("cpu_rvalid", 512'(cpu_rvalid), 512'(e_cpu_rvalid));
      check("cpu_rdata", 512'(cpu_rdata), 512'(e_cpu_rdata));
      check("acc_rvalid", 512'(acc_rvalid), 512'(e_acc_rvalid));
      check("acc_rdata", acc_rdata, e_acc_rdata);
      check("err", 512'(err), 512'(e_err));
    end
  end

  task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic errp);
    int n = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
    @(negedge clk);
    while (!cpu_ack && n < 50) begin n++; @(negedge clk); end
    if (!cpu_ack) begin
      n_tests++; n_fail++;
      $display("FAIL cpu_ack_timeout: no ack within %0d cycles", n);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("cpu_rvalid_lat", 512'(cpu_rvalid), 512'(!we));
    rd = cpu_rdata; errp = err;
  endtask

  task automatic acc_write(input logic [15:0] addr, input logic [31:0] wd, output logic errp);
    int n = 0;
    @(posedge clk); #1;
    acc_req = 1'b1; acc_we = 1'b1; acc_addr = addr; acc_wdata = wd;
    @(negedge clk);
    while (!acc_ack && n < 50) begin n++; @(negedge clk); end
    if (!acc_ack) begin
      n_tests++; n_fail++;
      $display("FAIL acc_wr_ack_timeout: no ack within %0d cycles", n);
    end
    @(posedge clk); #1;
    acc_req = 1'b0;
    @(negedge clk);
    errp = err;
  endtask

  task automatic acc_read(input logic [15:0] addr, output logic [511:0] data,
                          output int lat, output logic errp);
    int n = 0;
    @(posedge clk); #1;
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = addr;
    @(negedge clk);
    while (!acc_ack && n < 50) begin n++; @(negedge clk); end
    if (!acc_ack) begin
      n_tests++; n_fail++;
      $display("FAIL acc_rd_ack_timeout: no ack within %0d cycles", n);
    end
    @(posedge clk); #1;
    acc_req = 1'b0;
    lat = 1;
    @(negedge clk);
    errp = err;
    while (!acc_rvalid && lat < 300) begin lat++; @(negedge clk); end
    if (!acc_rvalid) begin
      n_tests++; n_fail++;
      $display("FAIL acc_rvalid_timeout: none within %0d cycles", lat);
    end
    data = acc_rdata;
  endtask

  logic [31:0]  rd;
  logic [511:0] wide, exp_k;
  logic         e;
  int           lat, c, drops, bad_phase, ack_c, rv_c, pulses;
  bit           acked;

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    acc_req = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0;
    for (int k = 0; k < 64; k++) exp_k[8*k +: 8] = 8'(k);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rvalid", 512'(cpu_rvalid), 512'(0));
    check("rst_acc_rdata", acc_rdata, 512'(0));
    check("rst_err", 512'(err), 512'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    cpu_op(1'b1, 16'h1000, 4'hF, 32'hDEADBEEF, rd, e);
    cpu_op(1'b0, 16'h1000, 4'h0, 32'h0, rd, e);
    check("rd_deadbeef", 512'(rd), 512'(32'hDEADBEEF));
    check("model_byte_1000", 512'(mem_m[16'h1000]), 512'(8'hEF));

    cpu_op(1'b1, 16'h2000, 4'hF, 32'hAABBCCDD, rd, e);
    cpu_op(1'b1, 16'h2000, 4'b0101, 32'h11223344, rd, e);
    cpu_op(1'b0, 16'h2000, 4'h0, 32'h0, rd, e);
    check("rd_byte_en", 512'(rd), 512'(32'hAA22CC44));

    cpu_op(1'b1, 16'h3004, 4'hF, 32'h00000000, rd, e);
    cpu_op(1'b1, 16'h3001, 4'hF, 32'h01020304, rd, e);
    cpu_op(1'b0, 16'h3002, 4'h0, 32'h0, rd, e);
    check("rd_unaligned", 512'(rd), 512'(32'h00010203));

    for (int w = 0; w < 16; w++)
      cpu_op(1'b1, 16'(16'h5000 + 4 * w), 4'hF,
             {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, rd, e);
    acc_read(16'h5000, wide, lat, e);
    check("burst_latency", 512'(lat), 512'(NB));
    check("burst_data", wide, exp_k);

    acc_write(16'h6000, 32'h99887766, e);
    check("acc_wr_err", 512'(e), 512'(0));
    cpu_op(1'b0, 16'h6000, 4'h0, 32'h0, rd, e);
    check("rd_acc_written", 512'(rd), 512'(32'h99887766));

    // CPU hammers reads while a burst runs; accel gets one slot per LIM+1 cycles.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 16'h5000;
    c = 0; drops = 0; bad_phase = 0; ack_c = -1; rv_c = -1; acked = 1'b0;
    while (c < 400) begin
      @(negedge clk);
      if (!cpu_ack) begin
        drops++;
        if (c % (LIM + 1) != LIM) bad_phase++;
      end
      if (acc_ack) begin ack_c = c; acked = 1'b1; end
      if (acc_rvalid) begin rv_c = c; break; end
      @(posedge clk); #1;
      if (acked) acc_req = 1'b0;
      c++;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; acc_req = 1'b0;
    check("starve_ack_cycle", 512'(ack_c), 512'(LIM));
    check("starve_drops", 512'(drops), 512'(NB));
    check("starve_phase", 512'(bad_phase), 512'(0));
    check("starve_done_cycle", 512'(rv_c), 512'(NB * (LIM + 1)));
    check("starve_data", acc_rdata, exp_k);

    cpu_op(1'b1, 16'hFFFC, 4'hF, 32'h12345678, rd, e);
    check("top_wr_err", 512'(e), 512'(0));
    cpu_op(1'b0, 16'hFFFE, 4'h0, 32'h0, rd, e);
    check("oob_cpu_rd_data", 512'(rd), 512'(0));
    check("oob_cpu_rd_err", 512'(e), 512'(1));
    acc_write(16'hFFFD, 32'hCAFEF00D, e);
    check("oob_acc_wr_err", 512'(e), 512'(1));
    cpu_op(1'b0, 16'hFFFC, 4'h0, 32'h0, rd, e);
    check("oob_mem_unchanged", 512'(rd), 512'(32'h12345678));
    acc_read(16'hFFC1, wide, lat, e);
    check("oob_acc_rd_err", 512'(e), 512'(1));
    check("oob_acc_rd_data", wide, 512'(0));
    check("oob_acc_rd_lat", 512'(lat), 512'(NB));

    // Abort a burst with reset while beat 5 is being fetched.
    @(posedge clk); #1;
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 16'h5000;
    @(negedge clk);
    check("rst_burst_ack", 512'(acc_ack), 512'(1));
    @(posedge clk); #1;
    acc_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_acc_rdata", acc_rdata, 512'(0));
    check("midrst_acc_rvalid", 512'(acc_rvalid), 512'(0));
    check("midrst_cpu_rdata", 512'(cpu_rdata), 512'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (acc_rvalid) pulses++;
    end
    check("midrst_no_rvalid", 512'(pulses), 512'(0));
    acc_read(16'h5000, wide, lat, e);
    check("post_rst_burst_data", wide, exp_k);
    check("post_rst_burst_lat", 512'(lat), 512'(NB));

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
